// File: rtl/register_file_pkg.sv
// Shared constants for the integer register file: default widths and the hard-wired zero register.
package register_file_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: selects a register by index, forces x0 to zero and,
// when REGFILE_BYPASS_EN is defined, forwards the in-flight writeback value on an index match.
module regfile_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
`ifdef REGFILE_BYPASS_EN
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
`endif
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = regs_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    if (wr_en_i && (wr_addr_i == addr_i)) begin
      data_o = wr_data_i;
    end
`endif
    // x0 wins over storage and forwarding alike.
    if (addr_i == ADDR_W'(REG_ZERO)) begin
      data_o = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// Two-read, one-write register file with async reset and x0 hard-wired to zero.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on read/write collisions.
module register_file
  import register_file_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] RD_W,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wr_en;

  // Writes to x0 are dropped here so storage slot 0 never leaves its reset value.
  assign wr_en = RegWriteW && (RD_W != ADDR_W'(REG_ZERO));

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[RD_W] = ResultW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so every read still returns zero.
  logic fwd_en;
  assign fwd_en = wr_en && !rst;
`endif

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .addr_i    (A1),
    .regs_i    (regs_q),
`ifdef REGFILE_BYPASS_EN
    .wr_en_i   (fwd_en),
    .wr_addr_i (RD_W),
    .wr_data_i (ResultW),
`endif
    .data_o    (RD1)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .addr_i    (A2),
    .regs_i    (regs_q),
`ifdef REGFILE_BYPASS_EN
    .wr_en_i   (fwd_en),
    .wr_addr_i (RD_W),
    .wr_data_i (ResultW),
`endif
    .data_o    (RD2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a reference model of the 32 registers feeds an
// expected-value queue that is drained against RD1/RD2 away from the rising clock edge.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RD_W;
  logic [31:0] ResultW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;

  logic [31:0] model [32];
  logic [31:0] exp_q [$];
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk       (clk),
    .rst       (rst),
    .RegWriteW (RegWriteW),
    .RD_W      (RD_W),
    .ResultW   (ResultW),
    .A1        (A1),
    .A2        (A2),
    .RD1       (RD1),
    .RD2       (RD2)
  );

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Drive one writeback cycle at the falling edge; after the rising edge park the
  // write bus at X with the enable low, which must never disturb storage.
  task automatic drive_write(input logic en, input logic [4:0] rd, input logic [31:0] d);
    @(negedge clk);
    RegWriteW = en;
    RD_W      = rd;
    ResultW   = d;
    @(posedge clk);
    if (en && (rd != 5'd0)) model[rd] = d;
    #1;
    RegWriteW = 1'b0;
    RD_W      = 'x;
    ResultW   = 'x;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    logic [4:0]  idx;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      idx = 5'($urandom_range(0, 31));
      A1 = idx;
      A2 = 5'd31 - idx;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); tests_run++;
      if (RD1 !== e) begin tests_failed++; $display("FAIL reset_rd1 A1=%0d: got %h want %h", A1, RD1, e); end
      e = exp_q.pop_front(); tests_run++;
      if (RD2 !== e) begin tests_failed++; $display("FAIL reset_rd2 A2=%0d: got %h want %h", A2, RD2, e); end
    end
    // A write held across a clock edge while in reset must not land or forward.
    RegWriteW = 1'b1; RD_W = 5'd4; ResultW = 32'hCAFEF00D; A1 = 5'd4;
    @(posedge clk); #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL reset_ignores_write: got %h want %h", RD1, e); end
    // Release reset with the write still pending: it lands on the next rising edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hCAFEF00D);
`else
    exp_q.push_back(32'h0);
`endif
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL release_pre_edge: got %h want %h", RD1, e); end
    @(posedge clk); #1;
    model[4] = 32'hCAFEF00D;
    exp_q.push_back(model[4]);
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL release_first_write: got %h want %h", RD1, e); end
    RegWriteW = 1'b0; RD_W = 'x; ResultW = 'x;
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    drive_write(1'b1, 5'd10, 32'h12345678);
    @(negedge clk);
    A1 = 5'd10; A2 = 5'd10;
    exp_q.push_back(32'h12345678);
    exp_q.push_back(32'h12345678);
    #1;
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL write_read_rd1: got %h want %h", RD1, e); end
    e = exp_q.pop_front(); tests_run++;
    if (RD2 !== e) begin tests_failed++; $display("FAIL write_read_rd2: got %h want %h", RD2, e); end
  endtask

  task automatic test_x0();
    logic [31:0] e;
    @(negedge clk);
    RegWriteW = 1'b1; RD_W = 5'd0; ResultW = 32'hFFFFFFFF; A1 = 5'd0; A2 = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL x0_pre_edge: got %h want %h", RD1, e); end
    @(posedge clk); #1;
    RegWriteW = 1'b0; RD_W = 'x; ResultW = 'x;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL x0_rd1: got %h want %h", RD1, e); end
    e = exp_q.pop_front(); tests_run++;
    if (RD2 !== e) begin tests_failed++; $display("FAIL x0_rd2: got %h want %h", RD2, e); end
  endtask

  task automatic test_no_write();
    logic [31:0] e;
    drive_write(1'b0, 5'd3, 32'hABCDABCD);
    @(negedge clk);
    A1 = 5'd3;
    exp_q.push_back(32'h0);
    #1;
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL no_write_x3: got %h want %h", RD1, e); end
  endtask

  task automatic test_collision();
    logic [31:0] e;
    drive_write(1'b1, 5'd7, 32'h11111111);
    @(negedge clk);
    RegWriteW = 1'b1; RD_W = 5'd7; ResultW = 32'h22222222; A1 = 5'd7; A2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h22222222);
`else
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h11111111);
`endif
    #1;
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL collision_pre_rd1: got %h want %h", RD1, e); end
    e = exp_q.pop_front(); tests_run++;
    if (RD2 !== e) begin tests_failed++; $display("FAIL collision_pre_rd2: got %h want %h", RD2, e); end
    @(posedge clk); #1;
    model[7] = 32'h22222222;
    RegWriteW = 1'b0; RD_W = 'x; ResultW = 'x;
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h22222222);
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL collision_post_rd1: got %h want %h", RD1, e); end
    e = exp_q.pop_front(); tests_run++;
    if (RD2 !== e) begin tests_failed++; $display("FAIL collision_post_rd2: got %h want %h", RD2, e); end
  endtask

  task automatic test_sweep();
    logic [31:0] e;
    for (int i = 1; i < 32; i++) drive_write(1'b1, 5'(i), i * 32'h01010101);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      exp_q.push_back(i * 32'h01010101);
      exp_q.push_back((31 - i) * 32'h01010101);
      #1;
      e = exp_q.pop_front(); tests_run++;
      if (RD1 !== e) begin tests_failed++; $display("FAIL sweep_rd1 A1=%0d: got %h want %h", A1, RD1, e); end
      e = exp_q.pop_front(); tests_run++;
      if (RD2 !== e) begin tests_failed++; $display("FAIL sweep_rd2 A2=%0d: got %h want %h", A2, RD2, e); end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int n = 0; n < 40; n++) begin
      drive_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      @(negedge clk);
      A1 = 5'($urandom_range(0, 31));
      A2 = 5'($urandom_range(0, 31));
      exp_q.push_back(model[A1]);
      exp_q.push_back(model[A2]);
      #1;
      e = exp_q.pop_front(); tests_run++;
      if (RD1 !== e) begin tests_failed++; $display("FAIL random_rd1 A1=%0d: got %h want %h", A1, RD1, e); end
      e = exp_q.pop_front(); tests_run++;
      if (RD2 !== e) begin tests_failed++; $display("FAIL random_rd2 A2=%0d: got %h want %h", A2, RD2, e); end
    end
  endtask

  task automatic test_reset_mid_cycle();
    logic [31:0] e;
    drive_write(1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    A1 = 5'd5; A2 = 5'd10;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL mid_reset_before: got %h want %h", RD1, e); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    clear_model();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL mid_reset_rd1: got %h want %h", RD1, e); end
    e = exp_q.pop_front(); tests_run++;
    if (RD2 !== e) begin tests_failed++; $display("FAIL mid_reset_rd2: got %h want %h", RD2, e); end
    @(negedge clk);
    rst = 1'b0;
    drive_write(1'b1, 5'd5, 32'h0BADF00D);
    @(negedge clk);
    exp_q.push_back(32'h0BADF00D);
    #1;
    e = exp_q.pop_front(); tests_run++;
    if (RD1 !== e) begin tests_failed++; $display("FAIL after_reset_write: got %h want %h", RD1, e); end
  endtask

  initial begin
    rst = 1'b1;
    RegWriteW = 1'b0;
    RD_W = 'x;
    ResultW = 'x;
    A1 = 5'd0;
    A2 = 5'd0;
    clear_model();
    test_reset();
    test_write_read();
    test_x0();
    test_no_write();
    test_collision();
    test_sweep();
    test_random();
    test_reset_mid_cycle();
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
